traffic_phase_scheduler: RTL and testbench
==========================================

# traffic_phase_scheduler

Single-clock phase scheduler that shares the intersection's right-of-way among three requesters: main street (the default holder), the side-street vehicle sensor and the pedestrian walk button. An emergency preempt input forces the intersection back to main green. It drives the `main`/`side` lamp triplets and `walk_light` directly. Timing comes from a one-cycle `tick` enable, normally the 1 s strobe, so there is no derived clock domain.

## Interface
- `MIN_GREEN_MAIN`, 12: minimum main-green ticks before a pending request can be served.
- `YELLOW`, 2: ticks in MAIN_Y and in SIDE_Y.
- `ALL_RED`, 1: all-red clearance ticks after every yellow and after WALK.
- `SIDE_GREEN`, 6: side-green ticks.
- `WALK`, 4: walk-light ticks.
- `TW`, 5: timer width. Every duration parameter must be in the range 1 to 2^TW-1.
- `fast_clock` in 1: sole clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the `fast_clock` rising edge; when low it overrides every other input.
- `tick` in 1: one-cycle enable, the time base.
- `walk_button` in 1: pedestrian request, level or pulse.
- `side_sensor` in 1: side-street vehicle present.
- `preempt` in 1: emergency request for main-street right-of-way, level.
- `main` out 3: main lamps. 100 = green, 010 = yellow, 001 = red.
- `side` out 3: side lamps, same encoding as `main`.
- `walk_light` out 1: 1 = walk.
- `walk_pending` out 1: latched pedestrian request.
- `side_pending` out 1: latched side request.
- `phase` out 3: current state. 0 MAIN_G, 1 MAIN_Y, 2 ALL_RED, 3 SIDE_G, 4 SIDE_Y, 5 WALK. Codes 6 and 7 are illegal and recover to MAIN_G.

## Operation
- Reset values:
  - `phase`=0, `main`=100, `side`=001, `walk_light`=0.
  - `walk_pending`=0, `side_pending`=0.
  - Timer=0, `last_served`=SIDE.
- Moore outputs, registered, decoded from the next state and updated on the same edge as `phase`:
  - MAIN_G: main 100, side 001.
  - MAIN_Y: main 010, side 001.
  - ALL_RED: main 001, side 001.
  - SIDE_G: main 001, side 100.
  - SIDE_Y: main 001, side 010.
  - WALK: main 001, side 001, walk_light 1.
  - `walk_light` is 0 in every state except WALK.
- Request latching, evaluated every cycle:
  - `walk_pending` is set by `walk_button`=1 in any state except WALK.
  - `side_pending` is set by `side_sensor`=1 in any state except SIDE_G and SIDE_Y.
  - A pending flag is cleared on the edge that grants its requester. If a set and a clear occur on the same edge, the clear wins.
- Timer: counts `tick`s in the current state and clears to 0 on every state change. "After N ticks" means the transition happens on the edge where `tick`=1 and timer=N-1.
- Transitions:
  - MAIN_G -> MAIN_Y: `tick`=1, timer >= MIN_GREEN_MAIN-1, (`walk_pending` or `side_pending`) and `preempt`=0. The timer saturates at MIN_GREEN_MAIN-1. With no request, MAIN_G holds indefinitely.
  - MAIN_Y -> ALL_RED after YELLOW ticks.
  - SIDE_Y -> ALL_RED after YELLOW ticks.
  - SIDE_G -> SIDE_Y after SIDE_GREEN ticks, or on the first edge with `preempt`=1 (no tick required).
  - WALK -> ALL_RED after WALK ticks, or on the first edge with `preempt`=1 (no tick required).
  - ALL_RED exit, after ALL_RED ticks, takes the first applicable rule:
    - `preempt`=1 -> MAIN_G.
    - Both flags pending -> grant the requester that is not `last_served`.
    - Only one flag pending -> grant that requester.
    - No flag pending -> MAIN_G.
  - Granting walk enters WALK; granting side enters SIDE_G. Each grant updates `last_served` and clears the granted pending flag.
- Preempt:
  - Holds MAIN_G while asserted.
  - Truncates SIDE_G and WALK.
  - MAIN_Y and SIDE_Y always run their full YELLOW duration; a yellow is never cut short.
  - Pending flags are retained through preempt.

## Timing
- Latency from a `tick` edge to the lamp change is 0 cycles: outputs change on the same edge as `phase`.
- Latency from `preempt` rising in SIDE_G or WALK to the state change is 1 edge.
- `tick` arriving on the same edge as a preempt-forced exit has no additional effect; the timer is cleared.
- `reset` low during any state: the next edge applies the reset values, and an in-flight request is discarded.
- `tick` held high for several cycles counts once per cycle; the bench must drive single-cycle pulses.

## Test plan
- No requests, 40 ticks after reset: `main`=100, `side`=001, `phase`=0 throughout, timer saturates.
- `side_sensor` pulse between ticks 2 and 3: `side_pending`=1.
  - MAIN_Y entered on tick 12.
  - ALL_RED on tick 14.
  - SIDE_G (main 001, side 100) on tick 15; `side_pending` clears on that edge.
  - SIDE_Y on tick 21, ALL_RED on tick 23, MAIN_G on tick 24.
- Walk and side both pending before tick 12:
  - WALK is granted first, because `last_served` resets to SIDE. `walk_light`=1 for 4 ticks.
  - Then ALL_RED, then SIDE_G for 6 ticks, then SIDE_Y, ALL_RED and MAIN_G.
- `preempt`=1 at SIDE_G timer=2, with `walk_pending`=1:
  - The next edge is SIDE_Y.
  - After 2 ticks ALL_RED, then MAIN_G.
  - MAIN_G holds while `preempt`=1 and `walk_pending` stays 1.
  - Once `preempt`=0, MAIN_Y on the next tick where timer >= 11.
- `walk_button` held high through WALK: no re-latch during WALK. Re-latches on the first cycle in ALL_RED.
- `reset`=0 mid-WALK with `side_pending`=1: the next edge gives `phase`=0, `main`=100, `walk_light`=0 and both pending flags 0.

Source files
------------

// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the phase scheduler and its environment.
// The master drives the requests and the time base; the slave (the scheduler) drives the lamps.
interface traffic_phase_scheduler_if;
  logic       tick;
  logic       walk_button;
  logic       side_sensor;
  logic       preempt;
  logic [2:0] main;
  logic [2:0] side;
  logic       walk_light;
  logic       walk_pending;
  logic       side_pending;
  logic [2:0] phase;

  modport master (
    output tick, walk_button, side_sensor, preempt,
    input  main, side, walk_light, walk_pending, side_pending, phase
  );

  modport slave (
    input  tick, walk_button, side_sensor, preempt,
    output main, side, walk_light, walk_pending, side_pending, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase scheduler: shares right-of-way between main street (default),
// a side-street sensor and a pedestrian button, with emergency preempt back to main green.
// All timing is counted in single-cycle tick enables.
module traffic_phase_scheduler #(
  parameter int unsigned MIN_GREEN_MAIN = 12,
  parameter int unsigned YELLOW         = 2,
  parameter int unsigned ALL_RED        = 1,
  parameter int unsigned SIDE_GREEN     = 6,
  parameter int unsigned WALK           = 4,
  parameter int unsigned TW             = 5
) (
  input  logic                        fast_clock,
  input  logic                        reset,
  traffic_phase_scheduler_if.slave    bus
);

  typedef enum logic [2:0] {
    S_MAIN_G  = 3'd0,
    S_MAIN_Y  = 3'd1,
    S_ALL_RED = 3'd2,
    S_SIDE_G  = 3'd3,
    S_SIDE_Y  = 3'd4,
    S_WALK    = 3'd5
  } state_t;

  // Last tick index of each timed phase ("after N ticks" fires when timer = N-1).
  localparam logic [TW-1:0] LP_MG_LAST = TW'(MIN_GREEN_MAIN - 1);
  localparam logic [TW-1:0] LP_Y_LAST  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] LP_AR_LAST = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] LP_SG_LAST = TW'(SIDE_GREEN - 1);
  localparam logic [TW-1:0] LP_W_LAST  = TW'(WALK - 1);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_walk_pending;
  logic          r_side_pending;
  logic          r_last_walk;     // 1 = walk served last, 0 = side served last
  logic [2:0]    r_main;
  logic [2:0]    r_side;
  logic          r_walk_light;

  state_t        w_next;
  logic [TW-1:0] w_timer_next;
  logic          w_grant_walk;
  logic          w_grant_side;
  logic          w_walk_pending_next;
  logic          w_side_pending_next;
  logic          w_last_walk_next;
  logic [2:0]    w_main;
  logic [2:0]    w_side;
  logic          w_walk_light;

  // Next-state selection and grant arbitration out of ALL_RED.
  always_comb begin
    w_next       = r_state;
    w_grant_walk = 1'b0;
    w_grant_side = 1'b0;
    case (r_state)
      S_MAIN_G: begin
        if (bus.tick && (r_timer >= LP_MG_LAST) &&
            (r_walk_pending || r_side_pending) && !bus.preempt)
          w_next = S_MAIN_Y;
      end
      S_MAIN_Y: begin
        if (bus.tick && (r_timer == LP_Y_LAST)) w_next = S_ALL_RED;
      end
      S_SIDE_Y: begin
        if (bus.tick && (r_timer == LP_Y_LAST)) w_next = S_ALL_RED;
      end
      S_SIDE_G: begin
        if (bus.preempt || (bus.tick && (r_timer == LP_SG_LAST))) w_next = S_SIDE_Y;
      end
      S_WALK: begin
        if (bus.preempt || (bus.tick && (r_timer == LP_W_LAST))) w_next = S_ALL_RED;
      end
      S_ALL_RED: begin
        if (bus.tick && (r_timer == LP_AR_LAST)) begin
          if (bus.preempt) begin
            w_next = S_MAIN_G;
          end else if (r_walk_pending && r_side_pending) begin
            if (r_last_walk) w_grant_side = 1'b1;
            else             w_grant_walk = 1'b1;
          end else if (r_walk_pending) begin
            w_grant_walk = 1'b1;
          end else if (r_side_pending) begin
            w_grant_side = 1'b1;
          end else begin
            w_next = S_MAIN_G;
          end
          if (w_grant_walk) w_next = S_WALK;
          if (w_grant_side) w_next = S_SIDE_G;
        end
      end
      default: w_next = S_MAIN_G;
    endcase
  end

  // Timer, request latches and last-served bookkeeping for the next edge.
  always_comb begin
    w_timer_next = r_timer;
    if (w_next != r_state) begin
      w_timer_next = '0;
    end else if (bus.tick) begin
      if ((r_state == S_MAIN_G) && (r_timer >= LP_MG_LAST)) w_timer_next = LP_MG_LAST;
      else                                                   w_timer_next = r_timer + 1'b1;
    end

    // A grant on the same edge as a new request clears the flag.
    w_walk_pending_next = (r_walk_pending || (bus.walk_button && (r_state != S_WALK)))
                          && !w_grant_walk;
    w_side_pending_next = (r_side_pending || (bus.side_sensor &&
                           (r_state != S_SIDE_G) && (r_state != S_SIDE_Y)))
                          && !w_grant_side;

    w_last_walk_next = r_last_walk;
    if (w_grant_walk) w_last_walk_next = 1'b1;
    if (w_grant_side) w_last_walk_next = 1'b0;
  end

  // Lamp decode from the next state so lamps change on the same edge as phase.
  always_comb begin
    w_main       = 3'b001;
    w_side       = 3'b001;
    w_walk_light = 1'b0;
    case (w_next)
      S_MAIN_G: w_main = 3'b100;
      S_MAIN_Y: w_main = 3'b010;
      S_SIDE_G: w_side = 3'b100;
      S_SIDE_Y: w_side = 3'b010;
      S_WALK:   w_walk_light = 1'b1;
      default:  ;
    endcase
  end

  // State, timer, request flags and registered lamp outputs.
  always_ff @(posedge fast_clock) begin
    if (!reset) begin
      r_state        <= S_MAIN_G;
      r_timer        <= '0;
      r_walk_pending <= 1'b0;
      r_side_pending <= 1'b0;
      r_last_walk    <= 1'b0;
      r_main         <= 3'b100;
      r_side         <= 3'b001;
      r_walk_light   <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_timer        <= w_timer_next;
      r_walk_pending <= w_walk_pending_next;
      r_side_pending <= w_side_pending_next;
      r_last_walk    <= w_last_walk_next;
      r_main         <= w_main;
      r_side         <= w_side;
      r_walk_light   <= w_walk_light;
    end
  end

  assign bus.phase        = r_state;
  assign bus.main         = r_main;
  assign bus.side         = r_side;
  assign bus.walk_light   = r_walk_light;
  assign bus.walk_pending = r_walk_pending;
  assign bus.side_pending = r_side_pending;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: a tick-counting reference model checked every cycle,
// plus directed scenarios with hand-derived phase expectations.
module tb_traffic_phase_scheduler;

  localparam int MGM = 12;
  localparam int YEL = 2;
  localparam int AR  = 1;
  localparam int SG  = 6;
  localparam int WK  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   mon_en;

  traffic_phase_scheduler_if bus();

  traffic_phase_scheduler #(
    .MIN_GREEN_MAIN(MGM), .YELLOW(YEL), .ALL_RED(AR),
    .SIDE_GREEN(SG), .WALK(WK), .TW(5)
  ) dut (
    .fast_clock(clk),
    .reset     (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase number plus number of ticks spent in it.
  int m_phase, m_cnt;
  bit m_wp, m_sp, m_lastw;
  int dur [6] = '{MGM, YEL, AR, SG, YEL, WK};

  always @(posedge clk) begin : model
    int p, nx, c;
    bit wp, sp, lw, gw, gs, done;
    if (!rst_n) begin
      m_phase <= 0; m_cnt <= 0; m_wp <= 1'b0; m_sp <= 1'b0; m_lastw <= 1'b0;
    end else begin
      p = m_phase; c = m_cnt; wp = m_wp; sp = m_sp; lw = m_lastw;
      nx = p; gw = 1'b0; gs = 1'b0;
      done = bus.tick && (c + 1 == dur[p]);
      case (p)
        0: if (bus.tick && (c + 1 >= MGM) && (wp || sp) && !bus.preempt) nx = 1;
        1, 4: if (done) nx = 2;
        3: if (bus.preempt || done) nx = 4;
        5: if (bus.preempt || done) nx = 2;
        2: if (done) begin
             if (bus.preempt) nx = 0;
             else if (wp && (!sp || !lw)) gw = 1'b1;
             else if (sp) gs = 1'b1;
             else nx = 0;
           end
        default: nx = 0;
      endcase
      if (gw) begin nx = 5; lw = 1'b1; end
      if (gs) begin nx = 3; lw = 1'b0; end
      wp = (wp || (bus.walk_button && p != 5)) && !gw;
      sp = (sp || (bus.side_sensor && p != 3 && p != 4)) && !gs;
      c  = (nx != p) ? 0 : c + int'(bus.tick);
      m_phase <= nx; m_cnt <= c; m_wp <= wp; m_sp <= sp; m_lastw <= lw;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_phase", int'(bus.phase), m_phase);
      chk("mon_main", int'(bus.main), (m_phase == 0) ? 4 : (m_phase == 1) ? 2 : 1);
      chk("mon_side", int'(bus.side), (m_phase == 3) ? 4 : (m_phase == 4) ? 2 : 1);
      chk("mon_walk_light", int'(bus.walk_light), int'(m_phase == 5));
      chk("mon_walk_pending", int'(bus.walk_pending), int'(m_wp));
      chk("mon_side_pending", int'(bus.side_pending), int'(m_sp));
    end
  end

  // One clock edge with the given tick value; inputs change 1 ns after edges.
  task automatic step(input bit t);
    bus.tick = t;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1); step(1'b0); step(1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic pulse_walk();
    bus.walk_button = 1'b1; step(1'b0); bus.walk_button = 1'b0;
  endtask

  task automatic pulse_side();
    bus.side_sensor = 1'b1; step(1'b0); bus.side_sensor = 1'b0;
  endtask

  // Pins both the DUT and the model to a hand-derived phase.
  task automatic pin_phase(input string nm, input int ph);
    chk({nm, "_dut"}, int'(bus.phase), ph);
    chk({nm, "_model"}, m_phase, ph);
  endtask

  initial begin
    checks = 0; failures = 0; mon_en = 1'b0;
    rst_n = 1'b0;
    bus.tick = 1'b0; bus.walk_button = 1'b0; bus.side_sensor = 1'b0; bus.preempt = 1'b0;
    @(posedge clk); #1;
    do_reset();
    mon_en = 1'b1;

    // Reset values
    pin_phase("rst_phase", 0);
    chk("rst_main", int'(bus.main), 4);
    chk("rst_side", int'(bus.side), 1);
    chk("rst_walk_light", int'(bus.walk_light), 0);
    chk("rst_wp", int'(bus.walk_pending), 0);
    chk("rst_sp", int'(bus.side_pending), 0);

    // No requests: main green holds
    tick_n(40);
    pin_phase("idle40", 0);
    chk("idle40_main", int'(bus.main), 4);

    // Side request cycle
    do_reset();
    tick_n(2);
    pulse_side();
    chk("side_latched", int'(bus.side_pending), 1);
    tick_n(9);  pin_phase("side_t11", 0);
    tick_n(1);  pin_phase("side_t12", 1);
    tick_n(2);  pin_phase("side_t14", 2);
    tick_n(1);  pin_phase("side_t15", 3);
    chk("side_t15_main", int'(bus.main), 1);
    chk("side_t15_side", int'(bus.side), 4);
    chk("side_t15_sp", int'(bus.side_pending), 0);
    tick_n(5);  pin_phase("side_t20", 3);
    tick_n(1);  pin_phase("side_t21", 4);
    tick_n(2);  pin_phase("side_t23", 2);
    tick_n(1);  pin_phase("side_t24", 0);

    // Walk and side both pending: walk first since side is last_served after reset
    do_reset();
    pulse_walk();
    pulse_side();
    tick_n(12); pin_phase("both_t12", 1);
    tick_n(2);  pin_phase("both_t14", 2);
    tick_n(1);  pin_phase("both_walk", 5);
    chk("both_walk_light", int'(bus.walk_light), 1);
    chk("both_sp_kept", int'(bus.side_pending), 1);
    tick_n(3);  pin_phase("both_walk3", 5);
    tick_n(1);  pin_phase("both_ar", 2);
    tick_n(1);  pin_phase("both_sideg", 3);
    tick_n(6);  pin_phase("both_sidey", 4);
    tick_n(2);  pin_phase("both_ar2", 2);
    tick_n(1);  pin_phase("both_main", 0);

    // Preempt truncates side green; pending walk retained
    do_reset();
    pulse_side();
    tick_n(15); pin_phase("pre_sideg", 3);
    tick_n(2);
    pulse_walk();
    bus.preempt = 1'b1;
    step(1'b0); pin_phase("pre_cut", 4);
    tick_n(2);  pin_phase("pre_ar", 2);
    tick_n(1);  pin_phase("pre_main", 0);
    chk("pre_wp_kept", int'(bus.walk_pending), 1);
    tick_n(15); pin_phase("pre_hold", 0);
    chk("pre_hold_wp", int'(bus.walk_pending), 1);
    bus.preempt = 1'b0;
    step(1'b0);
    tick_n(1);  pin_phase("pre_release", 1);
    tick_n(2);  pin_phase("pre_ar2", 2);
    tick_n(1);  pin_phase("pre_walk", 5);
    tick_n(1);
    bus.preempt = 1'b1;
    step(1'b0); pin_phase("pre_walk_cut", 2);
    tick_n(1);  pin_phase("pre_walk_main", 0);
    bus.preempt = 1'b0;

    // Walk button held through WALK: no re-latch until ALL_RED
    do_reset();
    bus.walk_button = 1'b1;
    tick_n(15); pin_phase("held_walk", 5);
    chk("held_wp_walk", int'(bus.walk_pending), 0);
    tick_n(3);  chk("held_wp_walk3", int'(bus.walk_pending), 0);
    step(1'b1); pin_phase("held_ar", 2);
    chk("held_wp_edge", int'(bus.walk_pending), 0);
    step(1'b0);
    chk("held_relatch", int'(bus.walk_pending), 1);
    bus.walk_button = 1'b0;
    tick_n(1);  pin_phase("held_rewalk", 5);

    // Reset mid-WALK discards requests
    do_reset();
    pulse_walk();
    tick_n(15); pin_phase("rw_walk", 5);
    pulse_side();
    chk("rw_sp", int'(bus.side_pending), 1);
    rst_n = 1'b0;
    step(1'b0);
    pin_phase("rw_phase", 0);
    chk("rw_main", int'(bus.main), 4);
    chk("rw_walk_light", int'(bus.walk_light), 0);
    chk("rw_wp", int'(bus.walk_pending), 0);
    chk("rw_sp0", int'(bus.side_pending), 0);
    rst_n = 1'b1;
    step(1'b0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
